// File: rtl/down_cnt_pkg.sv
// Shared types and helpers for the down-counter monitor.
package down_cnt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    TRACK,
    ERROR
  } mon_state_t;

  localparam int unsigned CNT_W_DEF  = 3;
  localparam int unsigned WRAP_W_DEF = 8;

  // Next value a healthy down counter should present: prev - 1 modulo 2^width.
  function automatic logic [31:0] cnt_expected(input logic [31:0] prev,
                                               input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (prev - 32'd1) & mask;
  endfunction

endpackage

// File: rtl/wrap_sat_counter.sv
// Saturating wrap counter; holds at all-ones once full.
module wrap_sat_counter #(
  parameter int unsigned WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [WRAP_W-1:0] count
);

  logic [WRAP_W-1:0] count_q;
  logic [WRAP_W-1:0] count_d;

  // Increment on request unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + WRAP_W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/down_count_monitor.sv
// Checker for a free-running down counter: verifies each accepted sample is
// prev-1, pulses on wraps, counts wraps, and latches an error after
// ERR_LIMIT consecutive mismatches.
// Optional: DOWN_MON_STALL_ERR_EN makes a stalled count a mismatch in TRACK.
module down_count_monitor
  import down_cnt_pkg::*;
#(
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned WRAP_W    = WRAP_W_DEF,
  parameter int unsigned ERR_LIMIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic              cnt_valid,
  input  logic              clr_err,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              zero_flag,
  output logic              locked,
  output logic              seq_err
);

  localparam int unsigned        MISS_W    = 3;
  localparam logic [MISS_W-1:0]  ERR_LIM_V = MISS_W'(ERR_LIMIT);

  mon_state_t        state_q, state_d;
  logic [CNT_W-1:0]  prev_q, prev_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              zero_q, zero_d;
  logic              pulse_q;
  logic              wrap_hit;

  logic [CNT_W-1:0]  exp_val;
  logic [MISS_W-1:0] miss_base;
  logic [MISS_W-1:0] miss_inc;
  logic              is_match;
  logic              stall_ok;

  assign exp_val   = CNT_W'(cnt_expected(32'(prev_q), CNT_W));
  assign is_match  = (cnt_in == exp_val);
  assign miss_base = clr_err ? '0 : miss_q;
  assign miss_inc  = miss_base + MISS_W'(1);

`ifdef DOWN_MON_STALL_ERR_EN
  assign stall_ok = 1'b0;
`else
  assign stall_ok = (cnt_in == prev_q);
`endif

  // Next-state and compare logic for the monitor FSM.
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    miss_d   = miss_q;
    zero_d   = zero_q;
    wrap_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        miss_d = miss_base;
        if (cnt_valid) begin
          prev_d  = cnt_in;
          zero_d  = (cnt_in == '0);
          state_d = SYNC;
        end
      end
      SYNC: begin
        miss_d = miss_base;
        if (cnt_valid) begin
          prev_d = cnt_in;
          zero_d = (cnt_in == '0);
          if (is_match) begin
            state_d = TRACK;
          end
        end
      end
      TRACK: begin
        miss_d = miss_base;
        if (cnt_valid) begin
          if (is_match) begin
            miss_d   = '0;
            prev_d   = cnt_in;
            zero_d   = (cnt_in == '0);
            wrap_hit = (prev_q == '0);
          end else if (!stall_ok) begin
            // A clear in the same cycle restarts the run before this miss counts.
            miss_d = miss_inc;
            prev_d = cnt_in;
            zero_d = (cnt_in == '0);
            if (miss_inc >= ERR_LIM_V) begin
              state_d = ERROR;
            end
          end
        end
      end
      ERROR: begin
        if (clr_err) begin
          state_d = IDLE;
          miss_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset overrides any pending wrap pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      prev_q  <= '0;
      miss_q  <= '0;
      zero_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      miss_q  <= miss_d;
      zero_q  <= zero_d;
      pulse_q <= wrap_hit;
    end
  end

  wrap_sat_counter #(
    .WRAP_W(WRAP_W)
  ) u_wrap_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (wrap_hit),
    .count(wrap_count)
  );

  assign wrap_pulse = pulse_q;
  assign zero_flag  = zero_q;
  assign locked     = (state_q == TRACK);
  assign seq_err    = (state_q == ERROR);

endmodule

// File: tb/tb_down_count_monitor.sv
// Directed scoreboard bench for down_count_monitor (WRAP_W=2, ERR_LIMIT=2).
module tb_down_count_monitor;

  typedef struct packed {
    logic       wp;
    logic [1:0] wc;
    logic       zf;
    logic       lk;
    logic       se;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [2:0] cnt_in;
  logic       cnt_valid;
  logic       clr_err;
  logic       wrap_pulse;
  logic [1:0] wrap_count;
  logic       zero_flag;
  logic       locked;
  logic       seq_err;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_idx = 0;

  down_count_monitor #(
    .CNT_W    (3),
    .WRAP_W   (2),
    .ERR_LIMIT(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_in    (cnt_in),
    .cnt_valid (cnt_valid),
    .clr_err   (clr_err),
    .wrap_pulse(wrap_pulse),
    .wrap_count(wrap_count),
    .zero_flag (zero_flag),
    .locked    (locked),
    .seq_err   (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic r, input logic v, input logic c, input logic [2:0] d,
                      input logic wp, input logic [1:0] wc, input logic zf,
                      input logic lk, input logic se);
    exp_t e;
    @(negedge clk);
    rst       = r;
    cnt_valid = v;
    clr_err   = c;
    cnt_in    = d;
    e.wp = wp; e.wc = wc; e.zf = zf; e.lk = lk; e.se = se;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are registered, so each issued vector is checked just after the next edge.
  initial begin
    exp_t e;
    exp_t act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        act.wp = wrap_pulse; act.wc = wrap_count; act.zf = zero_flag;
        act.lk = locked; act.se = seq_err;
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL vec%0d outputs: got wp=%b wc=%0d zf=%b lk=%b se=%b, expected wp=%b wc=%0d zf=%b lk=%b se=%b",
                   vec_idx, act.wp, act.wc, act.zf, act.lk, act.se,
                   e.wp, e.wc, e.zf, e.lk, e.se);
        end
        vec_idx++;
      end
    end
  end

  initial begin
    logic [1:0] wc_prev;
    logic [1:0] wc_k;
    rst = 1'b0; cnt_valid = 1'b0; clr_err = 1'b0; cnt_in = 3'd0;

    // reset for two cycles
    step(0, 0, 0, 3'd0, 0, 2'd0, 0, 0, 0);
    step(0, 0, 0, 3'd0, 0, 2'd0, 0, 0, 0);
    // 7 -> SYNC, 6 -> TRACK
    step(1, 1, 0, 3'd7, 0, 2'd0, 0, 0, 0);
    step(1, 1, 0, 3'd6, 0, 2'd0, 0, 1, 0);
    for (int c = 5; c >= 1; c--) step(1, 1, 0, 3'(c), 0, 2'd0, 0, 1, 0);
    step(1, 1, 0, 3'd0, 0, 2'd0, 1, 1, 0);
    // first wrap
    step(1, 1, 0, 3'd7, 1, 2'd1, 0, 1, 0);
    step(1, 0, 0, 3'd3, 0, 2'd1, 0, 1, 0);
    // stall ignored
    step(1, 1, 0, 3'd6, 0, 2'd1, 0, 1, 0);
    step(1, 1, 0, 3'd5, 0, 2'd1, 0, 1, 0);
    step(1, 1, 0, 3'd4, 0, 2'd1, 0, 1, 0);
    step(1, 1, 0, 3'd4, 0, 2'd1, 0, 1, 0);
    step(1, 1, 0, 3'd3, 0, 2'd1, 0, 1, 0);
    step(1, 1, 0, 3'd2, 0, 2'd1, 0, 1, 0);
    // two consecutive mismatches -> ERROR
    step(1, 1, 0, 3'd0, 0, 2'd1, 1, 1, 0);
    step(1, 1, 0, 3'd5, 0, 2'd1, 0, 0, 1);
    step(1, 1, 0, 3'd4, 0, 2'd1, 0, 0, 1);
    // clear wins over sample
    step(1, 1, 1, 3'd0, 0, 2'd1, 0, 0, 0);
    step(1, 1, 0, 3'd3, 0, 2'd1, 0, 0, 0);
    step(1, 1, 0, 3'd2, 0, 2'd1, 0, 1, 0);
    step(1, 1, 0, 3'd1, 0, 2'd1, 0, 1, 0);
    step(1, 1, 0, 3'd0, 0, 2'd1, 1, 1, 0);
    step(1, 1, 0, 3'd7, 1, 2'd2, 0, 1, 0);
    // wraps 3..5: count saturates at 3, pulse keeps firing
    for (int k = 3; k <= 5; k++) begin
      wc_prev = (k - 1 < 3) ? 2'(k - 1) : 2'd3;
      wc_k    = (k < 3) ? 2'(k) : 2'd3;
      for (int c = 6; c >= 1; c--) step(1, 1, 0, 3'(c), 0, wc_prev, 0, 1, 0);
      step(1, 1, 0, 3'd0, 0, wc_prev, 1, 1, 0);
      step(1, 1, 0, 3'd7, 1, wc_k, 0, 1, 0);
    end
    // reset on the wrap sample suppresses the pulse
    for (int c = 6; c >= 1; c--) step(1, 1, 0, 3'(c), 0, 2'd3, 0, 1, 0);
    step(1, 1, 0, 3'd0, 0, 2'd3, 1, 1, 0);
    step(0, 1, 0, 3'd7, 0, 2'd0, 0, 0, 0);
    step(1, 0, 0, 3'd0, 0, 2'd0, 0, 0, 0);
    // SYNC holds on a bad value; clr_err in TRACK clears the miss run
    step(1, 1, 0, 3'd7, 0, 2'd0, 0, 0, 0);
    step(1, 1, 0, 3'd3, 0, 2'd0, 0, 0, 0);
    step(1, 1, 0, 3'd2, 0, 2'd0, 0, 1, 0);
    step(1, 1, 0, 3'd0, 0, 2'd0, 1, 1, 0);
    step(1, 0, 1, 3'd0, 0, 2'd0, 1, 1, 0);
    step(1, 1, 0, 3'd5, 0, 2'd0, 0, 1, 0);
    step(1, 1, 0, 3'd4, 0, 2'd0, 0, 1, 0);
    step(1, 0, 0, 3'd0, 0, 2'd0, 0, 1, 0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/down_count_monitor.md
Name: down_count_monitor

Overview:
- Downstream checker for the free-running 3-bit down counter.
- Samples the counter's output bus and confirms each step is exactly −1 mod 2^CNT_W.
- Emits a one-cycle pulse on every wrap (0 → all-ones), keeps a saturating wrap count, and latches a sequence error after repeated mismatches.
- Sits between the counter and the status/interrupt logic.

Parameters:
- CNT_W, 3: width of the monitored count bus.
- WRAP_W, 8: width of the wrap counter.
- ERR_LIMIT, 2: consecutive mismatches in TRACK that force ERROR (legal range 1..7).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- cnt_in  in  CNT_W  count value from the upstream down counter.
- cnt_valid  in  1  cnt_in is sampled on this edge.
- clr_err  in  1  single-cycle request to clear the error condition.
- wrap_pulse  out  1  one-cycle pulse on an accepted wrap.
- wrap_count  out  WRAP_W  number of wraps seen; saturating.
- zero_flag  out  1  last accepted sample was 0.
- locked  out  1  monitor is in TRACK.
- seq_err  out  1  monitor is in ERROR.

Behaviour:
- Reset: sampled on clk while rst=0. Takes priority over everything.
  - State=IDLE; prev=0; miss=0.
  - All outputs 0.
- All outputs are registered. Response appears on the edge after the edge that samples cnt_valid=1, i.e. 1-cycle latency.
- Definitions:
  - expected = prev − 1, truncated to CNT_W, so 0 → 2^CNT_W−1.
  - A sample is accepted when cnt_valid=1. An accepted sample updates prev and zero_flag=(cnt_in==0), except where stated below.
  - stall: cnt_in == prev.
- IDLE:
  - First accepted sample loads prev → SYNC.
- SYNC:
  - cnt_in == expected → TRACK, locked=1.
  - Any other value → stay in SYNC.
  - No wrap pulses and no miss counting in SYNC.
- TRACK:
  - Match: miss cleared.
  - Match with prev==0 (a wrap): wrap_pulse=1 for one cycle; wrap_count increments, holding at 2^WRAP_W−1.
  - Stall: ignored. prev, miss and flags are unchanged.
  - Mismatch: miss += 1 and prev updated.
    - If miss reaches ERR_LIMIT → ERROR: seq_err=1, locked=0.
  - An upstream asynchronous reset to all-ones while prev≠0 is a mismatch.
- ERROR:
  - Samples are ignored; outputs hold.
  - clr_err=1 → IDLE: seq_err=0, miss=0.
- clr_err in IDLE, SYNC or TRACK clears miss only.
- clr_err together with cnt_valid in ERROR: the clear wins and the sample is discarded.
- wrap_count is cleared only by rst and survives ERROR and clr_err.
- cnt_valid=0: no state change. wrap_pulse returns to 0.
- Reset mid-wrap: the pending pulse is suppressed; all outputs are 0 on the next cycle.

Optional Feature:
- Macro: DOWN_MON_STALL_ERR_EN.
- Defined: a stall in TRACK counts as a mismatch (miss += 1, same ERR_LIMIT rule). For upstream counters that must never hold.
- Undefined: stalls are ignored as described above.

Decomposition:
- Package down_cnt_pkg holds:
  - enum typedef mon_state_t {IDLE, SYNC, TRACK, ERROR}, 2-bit.
  - Default constants CNT_W_DEF=3 and WRAP_W_DEF=8.
  - A function computing expected(prev).
- One sub-module, wrap_sat_counter (parameter WRAP_W; inputs clk, rst, inc; output count), implements the saturating wrap counter.
- The FSM and the compare logic stay in the top.

Test Plan:
- Feed rst=0 for 2 cycles, then cnt_valid=1 with 7,6,5 → locked=1 on the edge after sample "6"; wrap_count=0; seq_err=0.
- Run 7,6,…,0,7 in TRACK → wrap_pulse=1 for exactly one cycle, one edge after sample "7"; wrap_count=1; zero_flag=1 only after sample "0".
- With ERR_LIMIT=2 in TRACK, feed 5,3,1 → seq_err=1 and locked=0 after sample "1". Then feed clr_err=1 together with cnt_valid=1, cnt_in=0 → IDLE, seq_err=0, sample ignored.
- With WRAP_W=2, run 5 full wraps → wrap_count saturates at 3; wrap_pulse still pulses on each wrap.
- In TRACK, feed 4,4,3 → no error; miss=0 (macro undefined). With DOWN_MON_STALL_ERR_EN defined and ERR_LIMIT=1 → seq_err=1 after the second "4".
- Assert rst=0 on the cycle a wrap sample is accepted → wrap_pulse=0 and all outputs 0 on the next edge; wrap_count=0.
